// File: rtl/laby7_adder_arbiter.sv
`timescale 1ns/1ps
// laby7_adder_arbiter
//
// Round-robin arbiter and sequencer for one shared W-bit adder. Four
// requesters compete for the adder. Each transaction goes through three steps:
//   IDLE   : pick a winner, capture its operand pair, pulse its grant.
//   ADD    : the grant is high; the registered sum is formed at the edge.
//   RESULT : hold the sum and the winner's id until the consumer accepts it.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      request per requester, bit i belongs to requester i
//   a_in     packed operand A, requester i uses bits [i*W +: W]
//   b_in     packed operand B, same packing as a_in
//   gnt      registered one-hot grant, high for one cycle (the ADD cycle)
//   y        registered W+1 bit sum of the captured operands
//   y_id     index of the requester that owns y
//   y_valid  y / y_id are valid
//   y_ready  consumer accepts the result
module laby7_adder_arbiter #(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] a_in,
  input  logic [4*W-1:0] b_in,
  output logic [3:0]     gnt,
  output logic [W:0]     y,
  output logic [1:0]     y_id,
  output logic           y_valid,
  input  logic           y_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   id_q, id_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [W:0]   y_q, y_d;
  logic [1:0]   y_id_q, y_id_d;
  logic         y_valid_q, y_valid_d;

  logic [1:0]   winner;
  logic         any_req;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); the first asserted request
  // wins. The last-served requester is searched last, which gives fairness.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign any_req = |req;
  assign winner  = rr_pick(req, ptr_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    gnt_d     = 4'b0000;
    y_d       = y_q;
    y_id_d    = y_id_q;
    y_valid_d = y_valid_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          op_a_d  = a_in[int'(winner)*W +: W];
          op_b_d  = b_in[int'(winner)*W +: W];
          id_d    = winner;
          ptr_d   = winner;
          gnt_d   = 4'b0001 << winner;
          state_d = ADD;
        end
      end

      ADD: begin
        // Zero-extend before adding so the carry lands in the MSB.
        y_d       = {1'b0, op_a_q} + {1'b0, op_b_q};
        y_id_d    = id_q;
        y_valid_d = 1'b1;
        state_d   = RESULT;
      end

      RESULT: begin
        // y_valid is always high here, so the handshake reduces to y_ready.
        // y and y_id keep their values after the result is taken.
        if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        y_valid_d = 1'b0;
      end
    endcase
  end

  // ptr resets to 3 so requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      id_q      <= 2'd0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      gnt_q     <= 4'b0000;
      y_q       <= '0;
      y_id_q    <= 2'd0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      gnt_q     <= gnt_d;
      y_q       <= y_d;
      y_id_q    <= y_id_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign y       = y_q;
  assign y_id    = y_id_q;
  assign y_valid = y_valid_q;

endmodule
